// File: rtl/alb_pkg.sv
// Shared opcode encoding for the 4-bit ALB, its reference model and the chain sequencer,
// plus the sequencer FSM state encoding.
package alb_pkg;

    localparam logic [1:0] ALB_OR   = 2'b00;
    localparam logic [1:0] ALB_ADD  = 2'b01;
    localparam logic [1:0] ALB_ANDN = 2'b10;
    localparam logic [1:0] ALB_SUB  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alb_chain_seq_if.sv
// Request/result handshake bundle of the chain sequencer.
// master = requester and result consumer, slave = sequencer.
interface alb_chain_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_ci;
    logic [1:0]       op_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_f;
    logic             res_co;
    logic             res_vo;
    logic             res_no;
    logic             res_zo;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, op_ci, op_i, out_ready,
        input  in_ready, out_valid, res_f, res_co, res_vo, res_no, res_zo, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_ci, op_i, out_ready,
        output in_ready, out_valid, res_f, res_co, res_vo, res_no, res_zo, busy
    );
endinterface

// File: rtl/alb_chain_seq.sv
// Multi-nibble sequencer: feeds a WIDTH-bit operation through the 4-bit ALB LSB nibble first,
// chaining carry for ADD/SUB, and assembles the word result and flags.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// RUN     | driving nibble k on the ALB, waiting ALB_LAT+1 cycles per nibble
// DONE    | result held with out_valid high until out_ready
module alb_chain_seq
    import alb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALB_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    alb_chain_seq_if.slave        bus,
    output logic [3:0]            alb_r,
    output logic [3:0]            alb_s,
    output logic                  alb_ci,
    output logic [1:0]            alb_i,
    input  logic [3:0]            alb_f,
    input  logic                  alb_co,
    input  logic                  alb_vo,
    input  logic                  alb_no,
    input  logic                  alb_zo
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [1:0]    LAT_LD = 2'(ALB_LAT);

    seq_state_t       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ci_q;
    logic [1:0]       op_q;
    logic [KW-1:0]    k;
    logic [1:0]       wcnt;
    logic             zo_acc;

    logic             arith;
    logic [KW-1:0]    k_nxt;
    logic             nxt_ci;

    // Word sign comes from the assembled result, so the ALB's own NO flag is not needed.
    logic             unused_no;
    assign unused_no = alb_no;

    assign arith  = (op_q == ALB_ADD) || (op_q == ALB_SUB);
    assign k_nxt  = k + 1'b1;
    assign nxt_ci = arith ? alb_co : ci_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            ci_q          <= 1'b0;
            op_q          <= ALB_OR;
            k             <= '0;
            wcnt          <= '0;
            zo_acc        <= 1'b0;
            alb_r         <= '0;
            alb_s         <= '0;
            alb_ci        <= 1'b0;
            alb_i         <= '0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.res_f     <= '0;
            bus.res_co    <= 1'b0;
            bus.res_vo    <= 1'b0;
            bus.res_no    <= 1'b0;
            bus.res_zo    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= bus.op_a;
                        b_q          <= bus.op_b;
                        ci_q         <= bus.op_ci;
                        op_q         <= bus.op_i;
                        k            <= '0;
                        wcnt         <= LAT_LD;
                        zo_acc       <= 1'b1;
                        alb_r        <= bus.op_a[3:0];
                        alb_s        <= bus.op_b[3:0];
                        alb_ci       <= bus.op_ci;
                        alb_i        <= bus.op_i;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wcnt != 2'd0) begin
                        wcnt <= wcnt - 2'd1;
                    end else begin
                        // Terminal count: ALB outputs for nibble k are valid this cycle.
                        bus.res_f[4*k +: 4] <= alb_f;
                        zo_acc              <= zo_acc & alb_zo;
                        if (k == K_LAST) begin
                            bus.res_co    <= alb_co;
                            bus.res_vo    <= alb_vo;
                            bus.res_no    <= alb_f[3];
                            bus.res_zo    <= zo_acc & alb_zo;
                            bus.out_valid <= 1'b1;
                            state         <= ST_DONE;
                        end else begin
                            k      <= k_nxt;
                            wcnt   <= LAT_LD;
                            alb_r  <= a_q[4*k_nxt +: 4];
                            alb_s  <= b_q[4*k_nxt +: 4];
                            alb_ci <= nxt_ci;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
